// File: rtl/weight_stream_loader.sv
// rtl/weight_stream_loader.sv - BRAM weight reader packing LANES weights per streamed word
// Optional WSL_CHECKSUM_EN adds a 16-bit running sum of all weights on port checksum.
module weight_stream_loader #(
    parameter int W          = 8,
    parameter int LANES      = 4,
    parameter int ADDR_WIDTH = 18,
    parameter int CNT_WIDTH  = 18,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  count,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [W-1:0]          bram_dout,
    output logic [LANES*W-1:0]    out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
`ifdef WSL_CHECKSUM_EN
    ,
    output logic [15:0]           checksum
`endif
);

    localparam int DW   = LANES * W;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW  = $clog2(FIFO_DEPTH + 1);
    localparam int IW   = $clog2(RD_LAT + 1);
    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [CNT_WIDTH-1:0]  issue_left;
    logic [CNT_WIDTH-1:0]  pop_left;
    logic [RD_LAT:1]       pipe_vld;
    logic [IW-1:0]         inflight;
    logic [W-1:0]          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [FCW-1:0]        fifo_count;
    logic [W-1:0]          fifo_dout;
    logic [LW-1:0]         lane;

    logic start_acc, issue, credit_ok, fifo_wr, fifo_rd, accept, final_pop, word_full;

    // A read is only launched if its data is guaranteed a FIFO slot on return.
    assign credit_ok = (int'(inflight) + int'(fifo_count)) < FIFO_DEPTH;
    assign fifo_wr   = pipe_vld[RD_LAT];
    assign fifo_dout = fifo_mem[rd_ptr];
    assign accept    = out_valid && out_ready;
    assign fifo_rd   = (fifo_count != '0) && (!out_valid || out_ready);
    assign final_pop = fifo_rd && (pop_left == CNT_WIDTH'(1));
    assign word_full = fifo_rd && ((lane == LW'(LANES - 1)) || final_pop);

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        issue     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = (count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (issue_left == CNT_WIDTH'(1)) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (accept && out_last) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bram_en   = issue;
    assign bram_addr = rd_addr;
    assign busy      = (state == S_RUN) || (state == S_DRAIN);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rd_addr    <= '0;
            issue_left <= '0;
            pop_left   <= '0;
            pipe_vld   <= '0;
            inflight   <= '0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                rd_addr    <= base_addr;
                issue_left <= count;
                pop_left   <= count;
            end else begin
                if (issue) begin
                    rd_addr    <= rd_addr + ADDR_WIDTH'(1);
                    issue_left <= issue_left - CNT_WIDTH'(1);
                end
                if (fifo_rd) pop_left <= pop_left - CNT_WIDTH'(1);
            end
            pipe_vld[1] <= issue;
            for (int s = 2; s <= RD_LAT; s++) pipe_vld[s] <= pipe_vld[s-1];
            if (issue && !fifo_wr)      inflight <= inflight + IW'(1);
            else if (!issue && fifo_wr) inflight <= inflight - IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= bram_dout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (fifo_rd) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            if (fifo_wr && !fifo_rd)      fifo_count <= fifo_count + FCW'(1);
            else if (!fifo_wr && fifo_rd) fifo_count <= fifo_count - FCW'(1);
        end
    end

    // Lane 0 starts a fresh word, zeroing the lanes a short final word leaves unfilled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            lane      <= '0;
        end else begin
            if (fifo_rd) begin
                if (lane == '0) out_data <= DW'(fifo_dout);
                else            out_data[lane*W +: W] <= fifo_dout;
                lane <= word_full ? '0 : lane + LW'(1);
            end
            if (word_full) begin
                out_valid <= 1'b1;
                out_last  <= final_pop;
            end else if (accept) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

`ifdef WSL_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       checksum <= '0;
        else if (start_acc) checksum <= '0;
        else if (fifo_rd) checksum <= checksum + 16'(fifo_dout);
    end
`endif

endmodule

// File: tb/tb_weight_stream_loader.sv
// tb/tb_weight_stream_loader.sv - self-checking bench for weight_stream_loader
// Checks the checksum port as well when WSL_CHECKSUM_EN is defined.
module tb_weight_stream_loader;

    localparam int W      = 8;
    localparam int LANES  = 4;
    localparam int AW     = 18;
    localparam int CW     = 18;
    localparam int RD_LAT = 2;
    localparam int FD     = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic [CW-1:0]     count = '0;
    logic              bram_en;
    logic [AW-1:0]     bram_addr;
    logic [W-1:0]      bram_dout;
    logic [LANES*W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;
    logic              busy;
    logic              done;
`ifdef WSL_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0]       mem [0:(1<<AW)-1];
    logic [W-1:0]       rd_pipe [RD_LAT];
    logic [LANES*W-1:0] got_words [$];
    logic [AW-1:0]      got_addrs [$];
    logic [15:0]        last_sum;

    weight_stream_loader #(
        .W(W), .LANES(LANES), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .RD_LAT(RD_LAT), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done)
`ifdef WSL_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    // Read-only BRAM: data appears RD_LAT cycles after the enable cycle, garbage otherwise.
    always @(posedge clk) begin
        rd_pipe[0] <= bram_en ? mem[bram_addr] : 8'hEE;
        for (int s = 1; s < RD_LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
    end
    assign bram_dout = rd_pipe[RD_LAT-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready high, 1: random ready, 2: 20-cycle stall at first word, 3: stray start during RUN
    task automatic run_xfer(input string tag, input logic [AW-1:0] b, input logic [CW-1:0] c,
                            input int mode);
        logic [LANES*W-1:0] exp_w [$];
        logic [LANES*W-1:0] acc;
        logic [AW-1:0]      a;
        logic [15:0]        exp_sum;
        logic [LANES*W-1:0] prev_data;
        logic               prev_last, prev_stall;
        int lane, n, first_valid, done_cyc, last_acc, hold_viol, last_err, addr_err, max_out, acc_w;

        acc = '0; lane = 0; exp_sum = '0;
        for (int k = 0; k < int'(c); k++) begin
            a = b + AW'(k);
            acc[lane*W +: W] = mem[a];
            exp_sum += 16'(mem[a]);
            lane++;
            if (lane == LANES || k == int'(c) - 1) begin
                exp_w.push_back(acc);
                acc = '0;
                lane = 0;
            end
        end

        got_words.delete();
        got_addrs.delete();
        @(negedge clk);
        base_addr = b; count = c; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; first_valid = -1; done_cyc = -1; last_acc = -1;
        hold_viol = 0; last_err = 0; max_out = 0; prev_stall = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        while (done_cyc < 0 && n < 3000) begin
            if (first_valid < 0 && out_valid) first_valid = n;
            case (mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = !(first_valid >= 0 && n < first_valid + 20);
                default: out_ready = 1'b1;
            endcase
            if (mode == 3 && n == 3) begin
                start = 1'b1; base_addr = AW'($urandom); count = CW'($urandom_range(1, 9));
            end else begin
                start = 1'b0;
            end
            if (prev_stall && !(out_valid && out_data === prev_data && out_last === prev_last))
                hold_viol++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (bram_en) got_addrs.push_back(bram_addr);
            if (out_valid && out_ready) begin
                got_words.push_back(out_data);
                last_acc = n;
                if (out_last !== (got_words.size() == exp_w.size())) last_err++;
            end
            acc_w = got_words.size() * LANES;
            if (acc_w > int'(c)) acc_w = int'(c);
            if (got_addrs.size() - acc_w > max_out) max_out = got_addrs.size() - acc_w;
            if (done) begin
                done_cyc = n;
`ifdef WSL_CHECKSUM_EN
                last_sum = checksum;
`endif
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;

        check({tag, ".done_seen"}, 64'(done_cyc >= 0), 64'd1);
        check({tag, ".word_cnt"}, 64'(got_words.size()), 64'(exp_w.size()));
        for (int k = 0; k < exp_w.size() && k < got_words.size(); k++)
            check($sformatf("%s.word%0d", tag, k), 64'(got_words[k]), 64'(exp_w[k]));
        check({tag, ".read_cnt"}, 64'(got_addrs.size()), 64'(c));
        addr_err = 0;
        for (int k = 0; k < got_addrs.size(); k++)
            if (got_addrs[k] !== AW'(b + AW'(k))) addr_err++;
        check({tag, ".addr_err"}, 64'(addr_err), 64'd0);
        check({tag, ".last_err"}, 64'(last_err), 64'd0);
        check({tag, ".hold_viol"}, 64'(hold_viol), 64'd0);
        check({tag, ".outstanding_ok"}, 64'(max_out <= FD + LANES), 64'd1);
        check({tag, ".done_pulse_end"}, 64'(done), 64'd0);
        check({tag, ".busy_end"}, 64'(busy), 64'd0);
        if (c == '0) begin
            check({tag, ".zero_done_lat"}, 64'(done_cyc <= 2), 64'd1);
            check({tag, ".zero_no_valid"}, 64'(first_valid), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
            check({tag, ".done_after_last"}, 64'(done_cyc), 64'(last_acc + 1));
        end
        if (mode == 0 && int'(c) >= LANES)
            check({tag, ".first_latency"}, 64'(first_valid), 64'(RD_LAT + LANES + 1));
`ifdef WSL_CHECKSUM_EN
        check({tag, ".checksum"}, 64'(last_sum), 64'(exp_sum));
`endif
    endtask

    initial begin
        logic [AW-1:0] wexp [4];
        for (int i = 0; i < (1 << AW); i++) mem[i] = W'($urandom);
        for (int k = 0; k < 8; k++) mem[100 + k] = W'(k + 1);
        for (int s = 0; s < RD_LAT; s++) rd_pipe[s] = '0;

        repeat (3) @(negedge clk);
        check("reset.outputs", 64'({bram_en, bram_addr, out_data, out_valid, out_last, busy, done}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle.busy", 64'(busy), 64'd0);

        run_xfer("basic", AW'(100), CW'(8), 0);
        check("basic.w0_const", 64'(got_words[0]), 64'h04030201);
        check("basic.w1_const", 64'(got_words[1]), 64'h08070605);
`ifdef WSL_CHECKSUM_EN
        check("basic.checksum_const", 64'(last_sum), 64'd36);
`endif

        run_xfer("partial", AW'(100), CW'(6), 0);
        check("partial.w1_const", 64'(got_words[1]), 64'h00000605);
        check("partial.reads_const", 64'(got_addrs.size()), 64'd6);

        run_xfer("backpressure", AW'($urandom), CW'(40), 2);
        run_xfer("zero", AW'($urandom), CW'(0), 0);
        run_xfer("stray_start", AW'($urandom), CW'(20), 3);

        run_xfer("wrap", AW'((1 << AW) - 2), CW'(4), 0);
        wexp = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
        for (int k = 0; k < 4; k++)
            check($sformatf("wrap.addr%0d", k), 64'(got_addrs[k]), 64'(wexp[k]));

        for (int t = 0; t < 6; t++)
            run_xfer($sformatf("rand%0d", t), AW'($urandom), CW'($urandom_range(1, 40)),
                     $urandom_range(0, 2));

        @(negedge clk);
        base_addr = AW'($urandom); count = CW'(30); start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("midreset.busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midreset.outputs", 64'({bram_en, bram_addr, out_data, out_valid, out_last, busy, done}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_xfer("after_reset", AW'($urandom), CW'(13), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
